freq_gate_controller: RTL and testbench

Measurement sequencer for the OLED frequency counter. Runs in the 1 MHz reference domain and owns the measurement cycle of the clk_x pulse counter: clear, open gate for an exact number of reference cycles, close gate, wait for the counter's done indication, latch the count, and hand the result to the display formatter through a valid/ack handshake. Sits between the reset/clock generation and the counter/display path inside oled_frequency_counter.

---
 rtl/freq_gate_controller.sv | 263 ++++++++++++++++++++++++++
 tb/tb_freq_gate_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : freq_gate_controller
// Description : Measurement sequencer for the OLED frequency counter. Runs in
//               the reference clock domain and drives one measurement cycle of
//               the clk_x pulse counter: clear, settle, gate for an exact
//               number of reference cycles, settle, wait for done (with
//               timeout), latch the count and publish it to the display path
//               through a valid/ack handshake.
// Optional    : AUTORANGE_EN - three gate ranges (G, G/10, G/100) chosen
//               from the overflow/low-count history of previous measurements.
//               Undefined: fixed gate of GATE_CYCLES, range_out tied to 0.
// Ports       :
//   clk_ref_in          in   reference clock (only clock)
//   reset_in            in   synchronous active-high reset
//   run_in              in   level, 1 = continuous measurements
//   cnt_clear_out       out  clear request to the clk_x counter
//   cnt_gate_out        out  gate enable to the clk_x counter
//   cnt_done_in         in   counter value stable (already synchronized)
//   cnt_value_in        in   counter value, sampled with cnt_done_in
//   cnt_overflow_in     in   counter saturated, sampled with cnt_done_in
//   result_out          out  published count
//   result_overflow_out out  published overflow flag
//   result_valid_out    out  result available
//   result_ack_in       in   consumer has taken the result
//   range_out           out  gate range of the published measurement
//   busy_out            out  1 in every state except IDLE
//   timeout_out         out  sticky, last measurement timed out
// Revision    : 1.0 - initial release
// ============================================================================
module freq_gate_controller #(
  parameter int GATE_CYCLES    = 1000000,
  parameter int SETTLE_CYCLES  = 4,
  parameter int COUNT_W        = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk_ref_in,
  input  logic               reset_in,
  input  logic               run_in,
  output logic               cnt_clear_out,
  output logic               cnt_gate_out,
  input  logic               cnt_done_in,
  input  logic [COUNT_W-1:0] cnt_value_in,
  input  logic               cnt_overflow_in,
  output logic [COUNT_W-1:0] result_out,
  output logic               result_overflow_out,
  output logic               result_valid_out,
  input  logic               result_ack_in,
  output logic [1:0]         range_out,
  output logic               busy_out,
  output logic               timeout_out
);

  localparam int c_MAX_CYC = (GATE_CYCLES > TIMEOUT_CYCLES) ? GATE_CYCLES : TIMEOUT_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CYC + 1);

  // The shared counter is loaded with (duration - 1) on state entry and the
  // state is left on the cycle it reads zero.
  localparam logic [c_CNT_W-1:0] c_ONE        = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_LD_CLEAR   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_LD_SETTLE  = c_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_LD_TIMEOUT = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_LD_GATE0   = c_CNT_W'(GATE_CYCLES - 1);
`ifdef AUTORANGE_EN
  localparam logic [c_CNT_W-1:0] c_LD_GATE1   = c_CNT_W'(GATE_CYCLES / 10 - 1);
  localparam logic [c_CNT_W-1:0] c_LD_GATE2   = c_CNT_W'(GATE_CYCLES / 100 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_PRE     = 3'd2,
    S_GATE    = 3'd3,
    S_POST    = 3'd4,
    S_WAIT    = 3'd5,
    S_PUBLISH = 3'd6
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_clear;
  logic                 r_gate;
  logic                 r_busy;
  logic                 r_valid;
  logic                 r_timeout;
  logic [COUNT_W-1:0]   r_result;
  logic                 r_result_ovf;
  logic [COUNT_W-1:0]   r_hold_value;
  logic                 r_hold_ovf;
  logic                 r_hold_to;

  logic [c_CNT_W-1:0]   w_gate_load;
  logic [COUNT_W-1:0]   w_lat_value;
  logic                 w_lat_ovf;
  logic                 w_cnt_zero;
  logic                 w_wait_exit;

  // A timeout latches a zero count without overflow.
  assign w_lat_value = cnt_done_in ? cnt_value_in : '0;
  assign w_lat_ovf   = cnt_done_in & cnt_overflow_in;
  assign w_cnt_zero  = (r_cnt == '0);
  assign w_wait_exit = cnt_done_in | w_cnt_zero;

`ifdef AUTORANGE_EN
  logic [1:0] r_range;       // range for the next gate
  logic [1:0] r_hold_range;  // range of the measurement waiting to publish
  logic [1:0] r_range_out;
  logic       w_discard;
  logic       w_shrink;

  assign w_discard = w_lat_ovf & (r_range != 2'd2);
  assign w_shrink  = ~w_lat_ovf & (w_lat_value < COUNT_W'(10)) & (r_range != 2'd0);
  assign range_out = r_range_out;

  always_comb begin
    w_gate_load = c_LD_GATE0;
    case (r_range)
      2'd1:    w_gate_load = c_LD_GATE1;
      2'd2:    w_gate_load = c_LD_GATE2;
      default: w_gate_load = c_LD_GATE0;
    endcase
  end
`else
  assign w_gate_load = c_LD_GATE0;
  assign range_out   = 2'd0;
`endif

  always_ff @(posedge clk_ref_in) begin
    if (reset_in) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_clear      <= 1'b0;
      r_gate       <= 1'b0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
      r_result     <= '0;
      r_result_ovf <= 1'b0;
      r_hold_value <= '0;
      r_hold_ovf   <= 1'b0;
      r_hold_to    <= 1'b0;
`ifdef AUTORANGE_EN
      r_range      <= 2'd0;
      r_hold_range <= 2'd0;
      r_range_out  <= 2'd0;
`endif
    end else begin
      if (!w_cnt_zero) begin
        r_cnt <= r_cnt - c_ONE;
      end

      // Ack is honoured outside PUBLISH only; PUBLISH below re-asserts valid.
      if (result_ack_in && (r_state != S_PUBLISH)) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (run_in) begin
            r_state <= S_CLEAR;
            r_clear <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= c_LD_CLEAR;
          end
        end

        S_CLEAR: begin
          if (w_cnt_zero) begin
            r_state <= S_PRE;
            r_clear <= 1'b0;
            r_cnt   <= c_LD_SETTLE;
          end
        end

        S_PRE: begin
          if (w_cnt_zero) begin
            r_state <= S_GATE;
            r_gate  <= 1'b1;
            r_cnt   <= w_gate_load;
          end
        end

        S_GATE: begin
          if (w_cnt_zero) begin
            r_state <= S_POST;
            r_gate  <= 1'b0;
            r_cnt   <= c_LD_SETTLE;
          end
        end

        S_POST: begin
          if (w_cnt_zero) begin
            r_state <= S_WAIT;
            r_cnt   <= c_LD_TIMEOUT;
          end
        end

        S_WAIT: begin
          // done on the last timeout cycle still counts as a good result
          if (w_wait_exit) begin
            r_hold_value <= w_lat_value;
            r_hold_ovf   <= w_lat_ovf;
            r_hold_to    <= ~cnt_done_in;
            if (!cnt_done_in) begin
              r_timeout <= 1'b1;
            end
            r_state <= S_PUBLISH;
`ifdef AUTORANGE_EN
            r_hold_range <= r_range;
            if (w_discard) begin
              // overflowed on a wide gate: retry narrower without publishing
              r_range <= r_range + 2'd1;
              r_state <= S_CLEAR;
              r_clear <= 1'b1;
              r_cnt   <= c_LD_CLEAR;
            end else if (w_shrink) begin
              r_range <= r_range - 2'd1;
            end
`endif
          end
        end

        S_PUBLISH: begin
          r_result     <= r_hold_value;
          r_result_ovf <= r_hold_ovf;
          r_valid      <= 1'b1;
          if (!r_hold_to) begin
            r_timeout <= 1'b0;
          end
`ifdef AUTORANGE_EN
          r_range_out <= r_hold_range;
`endif
          if (run_in) begin
            r_state <= S_CLEAR;
            r_clear <= 1'b1;
            r_cnt   <= c_LD_CLEAR;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_clear <= 1'b0;
          r_gate  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_clear_out       = r_clear;
  assign cnt_gate_out        = r_gate;
  assign busy_out            = r_busy;
  assign result_valid_out    = r_valid;
  assign timeout_out         = r_timeout;
  assign result_out          = r_result;
  assign result_overflow_out = r_result_ovf;

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_freq_gate_controller
// Description : Directed self-checking bench for freq_gate_controller with
//               GATE_CYCLES=100, SETTLE_CYCLES=4, TIMEOUT_CYCLES=64.
//               Cycle c=0 is the first cycle the DUT sits in CLEAR; outputs
//               are sampled at the falling edge, inputs driven right after.
//               Timeline per measurement: CLEAR 0-1, PRE 2-5, GATE 6-105,
//               POST 106-109, WAIT_DONE from 110, done at 110 -> PUBLISH 111,
//               result visible from 112.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_gate_controller;

  logic        clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        run_in = 1'b0;
  logic        cnt_clear_out;
  logic        cnt_gate_out;
  logic        cnt_done_in = 1'b0;
  logic [31:0] cnt_value_in = '0;
  logic        cnt_overflow_in = 1'b0;
  logic [31:0] result_out;
  logic        result_overflow_out;
  logic        result_valid_out;
  logic        result_ack_in = 1'b0;
  logic [1:0]  range_out;
  logic        busy_out;
  logic        timeout_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  freq_gate_controller #(
    .GATE_CYCLES(100),
    .SETTLE_CYCLES(4),
    .COUNT_W(32),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_ref_in(clk),
    .reset_in(reset_in),
    .run_in(run_in),
    .cnt_clear_out(cnt_clear_out),
    .cnt_gate_out(cnt_gate_out),
    .cnt_done_in(cnt_done_in),
    .cnt_value_in(cnt_value_in),
    .cnt_overflow_in(cnt_overflow_in),
    .result_out(result_out),
    .result_overflow_out(result_overflow_out),
    .result_valid_out(result_valid_out),
    .result_ack_in(result_ack_in),
    .range_out(range_out),
    .busy_out(busy_out),
    .timeout_out(timeout_out)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // Leaves the bench at a falling edge with reset released and all inputs low.
  task automatic do_reset();
    reset_in = 1'b1; run_in = 1'b0; cnt_done_in = 1'b0;
    cnt_overflow_in = 1'b0; result_ack_in = 1'b0; cnt_value_in = '0;
    repeat (3) @(negedge clk);
    reset_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cnt_clear_out !== 1'b0) begin errors++; $display("FAIL reset_clear: got %b expected 0", cnt_clear_out); end
    checks++; if (cnt_gate_out !== 1'b0) begin errors++; $display("FAIL reset_gate: got %b expected 0", cnt_gate_out); end
    checks++; if (result_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", result_valid_out); end
    checks++; if (result_out !== 32'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
    checks++; if (timeout_out !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_out); end
    checks++; if (range_out !== 2'd0) begin errors++; $display("FAIL reset_range: got %0d expected 0", range_out); end
    reset_in = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ((busy_out !== 1'b0) || (cnt_clear_out !== 1'b0)) begin errors++; $display("FAIL idle_no_run: busy=%b clear=%b expected 0 0", busy_out, cnt_clear_out); end
  endtask

  task automatic test_basic();
    int clr_cnt = 0;
    int clr_first = -1;
    int gate_cnt = 0;
    int gate_first = -1;
    do_reset();
    run_in = 1'b1;
    cnt_value_in = 32'd12345;
    for (int c = 0; c <= 115; c++) begin
      @(negedge clk);
      if ((c < 114) && cnt_clear_out) begin clr_cnt++; if (clr_first < 0) clr_first = c; end
      if (cnt_gate_out) begin gate_cnt++; if (gate_first < 0) gate_first = c; end
      if (c == 113) begin
        checks++; if (result_valid_out !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b expected 0", result_valid_out); end
      end
      if (c == 114) begin
        checks++; if (result_valid_out !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", result_valid_out); end
        checks++; if (result_out !== 32'd12345) begin errors++; $display("FAIL basic_result: got %0d expected 12345", result_out); end
        checks++; if ((result_overflow_out !== 1'b0) || (timeout_out !== 1'b0) || (range_out !== 2'd0)) begin errors++; $display("FAIL basic_flags: ovf=%b to=%b range=%0d expected 0 0 0", result_overflow_out, timeout_out, range_out); end
        checks++; if ((cnt_clear_out !== 1'b1) || (busy_out !== 1'b1)) begin errors++; $display("FAIL basic_back_to_back: clear=%b busy=%b expected 1 1", cnt_clear_out, busy_out); end
      end
      cnt_done_in = (c == 112);
    end
    checks++; if (clr_first !== 0) begin errors++; $display("FAIL basic_clear_start: got %0d expected 0", clr_first); end
    checks++; if (clr_cnt !== 2) begin errors++; $display("FAIL basic_clear_len: got %0d expected 2", clr_cnt); end
    checks++; if (gate_first !== 6) begin errors++; $display("FAIL basic_gate_start: got %0d expected 6", gate_first); end
    checks++; if (gate_cnt !== 100) begin errors++; $display("FAIL basic_gate_len: got %0d expected 100", gate_cnt); end
    run_in = 1'b0; cnt_done_in = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    run_in = 1'b1;
    cnt_overflow_in = 1'b1;  // ignored: no done during the first measurement
    for (int c = 0; c <= 288; c++) begin
      @(negedge clk);
      if (c == 173) begin
        checks++; if ((timeout_out !== 1'b0) || (result_valid_out !== 1'b0)) begin errors++; $display("FAIL to_early: timeout=%b valid=%b expected 0 0", timeout_out, result_valid_out); end
      end
      if (c == 174) begin
        checks++; if (timeout_out !== 1'b1) begin errors++; $display("FAIL to_set: got %b expected 1", timeout_out); end
      end
      if (c == 175) begin
        checks++; if ((result_valid_out !== 1'b1) || (result_out !== 32'd0) || (result_overflow_out !== 1'b0)) begin errors++; $display("FAIL to_publish: valid=%b result=%0d ovf=%b expected 1 0 0", result_valid_out, result_out, result_overflow_out); end
        cnt_overflow_in = 1'b0;
      end
      if (c == 286) begin
        checks++; if (timeout_out !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_out); end
      end
      if (c == 287) begin
        checks++; if ((timeout_out !== 1'b0) || (result_out !== 32'd777) || (result_valid_out !== 1'b1)) begin errors++; $display("FAIL to_cleared: timeout=%b result=%0d valid=%b expected 0 777 1", timeout_out, result_out, result_valid_out); end
      end
      cnt_value_in = 32'd777;
      cnt_done_in = (c == 285);
    end
    run_in = 1'b0; cnt_done_in = 1'b0;
  endtask

  task automatic test_handshake();
    do_reset();
    run_in = 1'b1;
    for (int c = 0; c <= 336; c++) begin
      @(negedge clk);
      if (c == 112) begin
        checks++; if ((result_valid_out !== 1'b1) || (result_out !== 32'd100)) begin errors++; $display("FAIL hs_ack_in_publish: valid=%b result=%0d expected 1 100", result_valid_out, result_out); end
      end
      if (c == 113) begin
        checks++; if (result_valid_out !== 1'b0) begin errors++; $display("FAIL hs_ack_late: got %b expected 0", result_valid_out); end
      end
      if (c == 224) begin
        checks++; if ((result_valid_out !== 1'b1) || (result_out !== 32'd200)) begin errors++; $display("FAIL hs_second: valid=%b result=%0d expected 1 200", result_valid_out, result_out); end
      end
      if (c == 335) begin
        checks++; if ((result_valid_out !== 1'b1) || (result_out !== 32'd200)) begin errors++; $display("FAIL hs_stable: valid=%b result=%0d expected 1 200", result_valid_out, result_out); end
      end
      if (c == 336) begin
        checks++; if ((result_valid_out !== 1'b1) || (result_out !== 32'd300)) begin errors++; $display("FAIL hs_overwrite: valid=%b result=%0d expected 1 300", result_valid_out, result_out); end
      end
      cnt_done_in = (c == 110) || (c == 222) || (c == 334);
      cnt_value_in = (c < 200) ? 32'd100 : ((c < 300) ? 32'd200 : 32'd300);
      result_ack_in = (c == 111) || (c == 112);
    end
    run_in = 1'b0; cnt_done_in = 1'b0; result_ack_in = 1'b0;
  endtask

  task automatic test_run_drop();
    int gate_cnt = 0;
    int late_clr = 0;
    do_reset();
    run_in = 1'b1;
    cnt_value_in = 32'd42;
    for (int c = 0; c <= 150; c++) begin
      @(negedge clk);
      if (cnt_gate_out) gate_cnt++;
      if ((c >= 2) && cnt_clear_out) late_clr++;
      if (c == 111) begin
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL drop_busy_publish: got %b expected 1", busy_out); end
      end
      if (c == 112) begin
        checks++; if ((result_valid_out !== 1'b1) || (result_out !== 32'd42)) begin errors++; $display("FAIL drop_publish: valid=%b result=%0d expected 1 42", result_valid_out, result_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL drop_idle: busy=%b expected 0", busy_out); end
      end
      if (c == 50) run_in = 1'b0;
      cnt_done_in = (c == 110);
    end
    checks++; if (gate_cnt !== 100) begin errors++; $display("FAIL drop_gate_len: got %0d expected 100", gate_cnt); end
    checks++; if (late_clr !== 0) begin errors++; $display("FAIL drop_no_clear: got %0d clear cycles expected 0", late_clr); end
    cnt_done_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_in = 1'b1;
    cnt_value_in = 32'd55;
    for (int c = 0; c <= 136; c++) begin
      @(negedge clk);
      if (c == 132) begin
        checks++; if ((cnt_gate_out !== 1'b1) || (result_valid_out !== 1'b1)) begin errors++; $display("FAIL rmid_pre: gate=%b valid=%b expected 1 1", cnt_gate_out, result_valid_out); end
      end
      if (c == 133) begin
        checks++; if ((cnt_gate_out !== 1'b0) || (result_valid_out !== 1'b0) || (busy_out !== 1'b0) || (result_out !== 32'd0)) begin errors++; $display("FAIL rmid_reset: gate=%b valid=%b busy=%b result=%0d expected 0 0 0 0", cnt_gate_out, result_valid_out, busy_out, result_out); end
      end
      if (c == 134) begin
        checks++; if (cnt_clear_out !== 1'b0) begin errors++; $display("FAIL rmid_held: clear=%b expected 0", cnt_clear_out); end
      end
      if (c == 135) begin
        checks++; if ((cnt_clear_out !== 1'b1) || (busy_out !== 1'b1)) begin errors++; $display("FAIL rmid_restart: clear=%b busy=%b expected 1 1", cnt_clear_out, busy_out); end
      end
      cnt_done_in = (c == 110);
      reset_in = (c == 132) || (c == 133);
    end
    run_in = 1'b0; cnt_done_in = 1'b0;
  endtask

`ifdef AUTORANGE_EN
  task automatic test_autorange();
    int gate_short = 0;
    int gate_long = 0;
    do_reset();
    run_in = 1'b1;
    for (int c = 0; c <= 245; c++) begin
      @(negedge clk);
      if ((c >= 111) && (c <= 132) && cnt_gate_out) gate_short++;
      if ((c >= 133) && cnt_gate_out) gate_long++;
      if (c == 111) begin
        checks++; if ((cnt_clear_out !== 1'b1) || (busy_out !== 1'b1)) begin errors++; $display("FAIL ar_discard: clear=%b busy=%b expected 1 1", cnt_clear_out, busy_out); end
      end
      if (c == 112) begin
        checks++; if (result_valid_out !== 1'b0) begin errors++; $display("FAIL ar_no_publish: valid=%b expected 0", result_valid_out); end
      end
      if (c == 133) begin
        checks++; if ((result_valid_out !== 1'b1) || (range_out !== 2'd1) || (result_out !== 32'd5)) begin errors++; $display("FAIL ar_publish: valid=%b range=%0d result=%0d expected 1 1 5", result_valid_out, range_out, result_out); end
      end
      cnt_done_in = (c == 110) || (c == 131);
      cnt_overflow_in = (c == 110);
      cnt_value_in = (c == 110) ? 32'hFFFF_FFFF : 32'd5;
    end
    checks++; if (gate_short !== 10) begin errors++; $display("FAIL ar_gate_range1: got %0d expected 10", gate_short); end
    checks++; if (gate_long !== 100) begin errors++; $display("FAIL ar_gate_range0: got %0d expected 100", gate_long); end
    run_in = 1'b0; cnt_done_in = 1'b0; cnt_overflow_in = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_handshake();
    test_run_drop();
    test_reset_mid();
`ifdef AUTORANGE_EN
    test_autorange();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
